event_encoder: RTL and testbench
================================

Name: event_encoder

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 `sel`→`res` decoder.
- Captures one-hot or multi-hot event pulses into sticky pending bits.
- Emits their indices one at a time as a binary code, using a valid/ready handshake.
- Sits between peripheral event sources and a consumer that takes one index per transfer, e.g. an interrupt/dispatch unit.

Parameters:
- N, 8, number of event inputs (N ≥ 2).
- W, $clog2(N) (derived localparam, default 3), code width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset (fixed: one clock; reset asynchronous and active-low).
- evt  input  N  event strobes, sampled every clk edge; bit i high = event i occurred.
- ready  input  1  consumer accepts code this cycle.
- res  output  W  encoded index of the event being offered.
- valid  output  1  res holds a valid code.
- pend  output  N  pending events not yet loaded into res.
- drop  output  1  one-cycle pulse: an event was merged into an already-pending bit.

Behaviour:
- Reset (asynchronous, immediate on rst_n low): res=0, valid=0, pend=0, drop=0. Reset mid-transfer discards the held code and all pending events; no partial state survives.
- Candidate vector: cand = pend | evt.
- Selection: lowest-index set bit of cand wins; bit 0 has highest priority.
- Load condition: load = !valid | (valid & ready).
- States:
  - EMPTY (valid=0).
    - cand≠0 → load; go to HOLD.
    - Otherwise stay in EMPTY.
  - HOLD (valid=1).
    - ready=0 → res and valid held stable; pend absorbs evt.
    - ready=1 and cand≠0 → load the next code; stay in HOLD (back-to-back, one code per cycle).
    - ready=1 and cand=0 → valid=0; go to EMPTY.
- On load of index k:
  - res ← k, valid ← 1.
  - pend ← cand with bit k cleared.
- When not loading: pend ← cand.
- Latency: evt bit high at edge e with pipeline empty → res/valid visible after edge e (1 cycle). Zero-cycle combinational bypass is forbidden; res and valid are registers.
- Throughput: 1 code per cycle while ready=1.
- Code in res is already removed from pend. The same event bit asserted again while its code is held in res sets pend[k] (new event; not a drop).
- drop:
  - Registered pulse, asserted the cycle after any edge where evt[i] & pend[i] for some i.
  - Exception: when bit i is being loaded at that same edge, it is not a drop; the event re-sets pend[i].
  - Multiple merges in one edge produce a single drop pulse.
- evt held high for M cycles counts as M events. The source must pulse; the 2nd..Mth cycles produce drops if still pending.
- evt=0 and pend=0 with valid=0: block idle; all outputs stable.
- All-ones evt: codes emitted in ascending order 0..N-1, no loss.
- No X on outputs after reset release; ready while valid=0 is ignored.

Decomposition:
- Shared package `enc_pkg`: default N, W=$clog2(N), state encoding constants ST_EMPTY/ST_HOLD.
- One combinational sub-module `prio_enc` (N→W lowest-set-bit encoder plus `any` flag), instanced once on cand.
- Top holds the pend/res/valid/drop registers and the state logic.

Test Plan:
- Reset: rst_n=0 with evt=8'hFF → res=0, valid=0, pend=0, drop=0 immediately; after release, first evt accepted normally.
- Single event: ready=1, evt=8'b0000_0100 for 1 cycle → next cycle res=3'd2, valid=1 for exactly 1 cycle, pend=0, drop=0.
- Priority order: ready=1, evt=8'b1000_0001 for 1 cycle → res=0 then res=7 on consecutive cycles; valid low on the third cycle.
- Backpressure and drop:
  - ready=0, evt=8'h10 pulse → res=4, valid=1 held stable.
  - Second 8'h10 pulse → pend=8'h10, drop=0.
  - Third pulse → drop=1 for one cycle, pend unchanged.
  - Raise ready → res=4 twice total, then valid=0.
- Burst: evt=8'hFF for 1 cycle, ready=1 → res=0..7 over 8 consecutive cycles; pend shrinks one bit per cycle to 0.
- Async reset mid-burst: evt=8'hFF, ready toggling, rst_n low between edges while valid=1 → outputs zero without a clock edge; no stale code after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for the event encoder: default event count and FSM state codes.
package enc_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = $clog2(N_DEF);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/prio_enc.sv
// Combinational lowest-set-bit priority encoder; bit 0 has the highest priority.
module prio_enc
  import enc_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? W'(i) : idx_o;
    end
  end

  // Flag that at least one candidate is present.
  always_comb begin
    any_o = |vec_i;
  end

endmodule

// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder: sticky pending bits drained one index
// per valid/ready transfer, with a one-cycle drop pulse on merged events.
module event_encoder
  import enc_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] evt,
  input  logic         ready,
  output logic [W-1:0] res,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         drop
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] res_q, res_d;
  logic [0:0]   state_q, state_d;
  logic         drop_q, drop_d;

  logic [N-1:0] cand;
  logic [N-1:0] sel_mask;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         load;
  logic         take;

  assign cand = pend_q | evt;
  assign load = (state_q == ST_EMPTY) | ((state_q == ST_HOLD) & ready);
  assign take = load & sel_any;

  prio_enc #(.N(N)) u_prio (
    .vec_i (cand),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign sel_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;

  // Next-state: load the winning index, or keep absorbing events into pend.
  always_comb begin
    res_d   = res_q;
    state_d = state_q;
    pend_d  = cand;
    // A bit being loaded while it was already pending keeps the fresh event pending.
    drop_d  = |(evt & pend_q & ~(take ? sel_mask : {N{1'b0}}));
    case (state_q)
      ST_EMPTY: begin
        if (sel_any) begin
          res_d   = sel_idx;
          state_d = ST_HOLD;
          pend_d  = (cand & ~sel_mask) | (evt & pend_q & sel_mask);
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (!ready) begin
          state_d = ST_HOLD;
        end else if (sel_any) begin
          res_d   = sel_idx;
          state_d = ST_HOLD;
          pend_d  = (cand & ~sel_mask) | (evt & pend_q & sel_mask);
        end else begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        pend_d  = {N{1'b0}};
      end
    endcase
  end

  // State and output registers; reset discards any held code and pending events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= {W{1'b0}};
      state_q <= ST_EMPTY;
      pend_q  <= {N{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign res   = res_q;
  assign valid = (state_q == ST_HOLD);
  assign pend  = pend_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed vector table, async-reset
// corner cases and randomized traffic against a set-based reference model.
module tb_event_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] evt;
  logic       ready;
  logic [2:0] res;
  logic       valid;
  logic [7:0] pend;
  logic       drop;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the consumer should see after each edge.
  int         m_res;
  bit         m_valid;
  bit [7:0]   m_pend;
  bit         m_drop;

  typedef struct {
    logic [7:0] evt;
    logic       ready;
    logic [2:0] exp_res;
    logic       exp_valid;
    logic [7:0] exp_pend;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[$];

  event_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .evt   (evt),
    .ready (ready),
    .res   (res),
    .valid (valid),
    .pend  (pend),
    .drop  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic [7:0] e, logic r, logic [2:0] er, logic ev,
                              logic [7:0] ep, logic ed);
    vec_t v;
    v.evt = e; v.ready = r; v.exp_res = er; v.exp_valid = ev;
    v.exp_pend = ep; v.exp_drop = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [2:0] er, logic ev, logic [7:0] ep,
                     logic ed, bit cmp_res);
    checks++;
    if (valid !== ev || pend !== ep || drop !== ed || ((ev || cmp_res) && res !== er)) begin
      errors++;
      $display("FAIL %s: got res=%0d valid=%0b pend=%02h drop=%0b, expected res=%0d valid=%0b pend=%02h drop=%0b",
               nm, res, valid, pend, drop, er, ev, ep, ed);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_valid = 0; m_pend = 8'h00; m_drop = 0;
  endtask

  // One clock edge of the spec: pick the lowest pending-or-new event if the slot is free.
  task automatic model_edge(input logic [7:0] e, input logic r);
    bit [7:0] old_p = m_pend;
    bit [7:0] c     = m_pend | e;
    bit       can   = !m_valid || r;
    int       k     = -1;
    if (can) begin
      for (int i = 0; i < 8; i++) begin
        if (c[i] && k < 0) k = i;
      end
    end
    m_drop = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i] && old_p[i] && !(k == i)) m_drop = 1;
    end
    if (k >= 0) begin
      m_res   = k;
      m_valid = 1;
      c[k]    = e[k] && old_p[k];
    end else if (can) begin
      m_valid = 0;
    end
    m_pend = c;
  endtask

  task automatic step(input logic [7:0] e, input logic r);
    @(negedge clk);
    evt   = e;
    ready = r;
    @(posedge clk);
    model_edge(e, r);
    #1;
  endtask

  initial begin
    evt   = 8'hFF;
    ready = 1'b0;
    rst_n = 1'b0;
    model_reset();

    #3;
    chk("reset_hold", 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clocked", 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    evt   = 8'h00;
    rst_n = 1'b1;

    // Directed vectors: single, priority, backpressure/drop, reload exception, burst.
    add(8'h04, 1'b1, 3'd2, 1'b1, 8'h00, 1'b0);
    add(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
    add(8'h81, 1'b1, 3'd0, 1'b1, 8'h80, 1'b0);
    add(8'h00, 1'b1, 3'd7, 1'b1, 8'h00, 1'b0);
    add(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
    add(8'h10, 1'b0, 3'd4, 1'b1, 8'h00, 1'b0);
    add(8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0);
    add(8'h10, 1'b0, 3'd4, 1'b1, 8'h10, 1'b1);
    add(8'h00, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0);
    add(8'h00, 1'b1, 3'd4, 1'b1, 8'h00, 1'b0);
    add(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
    add(8'h02, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0);
    add(8'h02, 1'b0, 3'd1, 1'b1, 8'h02, 1'b0);
    add(8'h02, 1'b1, 3'd1, 1'b1, 8'h02, 1'b0);
    add(8'h00, 1'b1, 3'd1, 1'b1, 8'h00, 1'b0);
    add(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
    add(8'hFF, 1'b1, 3'd0, 1'b1, 8'hFE, 1'b0);
    for (int i = 1; i < 8; i++) begin
      logic [7:0] ones;
      ones = 8'hFF;
      add(8'h00, 1'b1, 3'(i), 1'b1, ones << (i + 1), 1'b0);
    end
    add(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].evt, vecs[i].ready);
      chk($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_valid,
          vecs[i].exp_pend, vecs[i].exp_drop, 1'b0);
    end

    // Async reset mid-burst, asserted away from any clock edge.
    step(8'hFF, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    chk("burst_before_rst", 3'd1, 1'b1, 8'hFC, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mid", 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 1'b1);
    chk("after_rst_idle", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(8'h20, 1'b1);
    chk("after_rst_event", 3'd5, 1'b1, 8'h00, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] e;
      logic       r;
      e = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      r = ($urandom_range(0, 3) != 0);
      step(e, r);
      chk($sformatf("rand%0d", n), 3'(m_res), m_valid, m_pend, m_drop, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
